imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe.sv | 168 ++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator behind a two-entry (output + skid) ready/valid stage.
// Each entry carries the instruction together with its decoded immediate and format.
module imm_gen_pipe #(
    parameter int XLEN   = 32,
    parameter bit EN_CSR = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [XLEN-1:0]   out_imm,
    output logic [2:0]        out_fmt,
    output logic              out_illegal,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  illegal_cnt
);

    localparam logic [2:0] FMT_I    = 3'd0;
    localparam logic [2:0] FMT_S    = 3'd1;
    localparam logic [2:0] FMT_B    = 3'd2;
    localparam logic [2:0] FMT_U    = 3'd3;
    localparam logic [2:0] FMT_J    = 3'd4;
    localparam logic [2:0] FMT_Z    = 3'd5;
    localparam logic [2:0] FMT_NONE = 3'd7;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            ill;
    } entry_t;

    localparam entry_t ENTRY_RST = '{inst: '0, imm: '0, fmt: FMT_NONE, ill: 1'b0};

    logic [31:0] dec_imm32;
    logic [XLEN-1:0] dec_imm;
    logic [2:0] dec_fmt;
    logic dec_ill;
    entry_t dec_entry;

    entry_t out_q, out_d, skid_q, skid_d;
    logic out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic accept, drain;

    // The 32-bit immediate already has its sign bit at [31]; zimm stays below it.
    always_comb begin
        dec_imm32 = '0;
        dec_fmt   = FMT_NONE;
        dec_ill   = 1'b0;
        case (in_inst[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: begin
                dec_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
                dec_fmt   = FMT_I;
            end
            7'b0011011: begin
                if (XLEN == 64) begin
                    dec_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
                    dec_fmt   = FMT_I;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            7'b0111011: dec_ill = (XLEN != 64);
            7'b0100011: begin
                dec_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
                dec_fmt   = FMT_S;
            end
            7'b1100011: begin
                dec_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                             in_inst[30:25], in_inst[11:8], 1'b0};
                dec_fmt   = FMT_B;
            end
            7'b0110111, 7'b0010111: begin
                dec_imm32 = {in_inst[31:12], 12'b0};
                dec_fmt   = FMT_U;
            end
            7'b1101111: begin
                dec_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                             in_inst[20], in_inst[30:21], 1'b0};
                dec_fmt   = FMT_J;
            end
            7'b1110011: begin
                if (EN_CSR && in_inst[14]) begin
                    dec_imm32 = {27'b0, in_inst[19:15]};
                    dec_fmt   = FMT_Z;
                end
            end
            7'b0110011, 7'b0001111: ;
            default: dec_ill = 1'b1;
        endcase
    end

    generate
        if (XLEN > 32) begin : g_sext
            assign dec_imm = {{(XLEN-32){dec_imm32[31]}}, dec_imm32};
        end else begin : g_nosext
            assign dec_imm = dec_imm32;
        end
    endgenerate

    assign dec_entry = '{inst: in_inst, imm: dec_imm, fmt: dec_fmt, ill: dec_ill};

    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid_q && out_ready;

    // Skid can only be occupied while the output register is, so refill from skid first.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (!out_valid_q || drain) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = dec_entry;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = (accept && dec_ill) ? CNT_W'(1) : '0;
        end else if (accept && dec_ill && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= ENTRY_RST;
            skid_q       <= ENTRY_RST;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_inst    = out_q.inst;
    assign out_imm     = out_q.imm;
    assign out_fmt     = out_q.fmt;
    assign out_illegal = out_q.ill;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit/CSR instance and a 64-bit/no-CSR/4-bit-counter
// instance share one stimulus stream and are checked against a queue-based model.
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        cnt_clr = 1'b0;
    logic [31:0] in_inst = '0;

    logic        in_ready_0, out_valid_0, out_illegal_0;
    logic [31:0] out_inst_0, out_imm_0;
    logic [2:0]  out_fmt_0;
    logic [15:0] illegal_cnt_0;

    logic        in_ready_1, out_valid_1, out_illegal_1;
    logic [31:0] out_inst_1;
    logic [63:0] out_imm_1;
    logic [2:0]  out_fmt_1;
    logic [3:0]  illegal_cnt_1;

    int checks = 0;
    int errors = 0;

    imm_gen_pipe #(.XLEN(32), .EN_CSR(1'b1), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_0),
        .in_inst(in_inst), .out_valid(out_valid_0), .out_ready(out_ready),
        .out_inst(out_inst_0), .out_imm(out_imm_0), .out_fmt(out_fmt_0),
        .out_illegal(out_illegal_0), .cnt_clr(cnt_clr), .illegal_cnt(illegal_cnt_0)
    );

    imm_gen_pipe #(.XLEN(64), .EN_CSR(1'b0), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_1),
        .in_inst(in_inst), .out_valid(out_valid_1), .out_ready(out_ready),
        .out_inst(out_inst_1), .out_imm(out_imm_1), .out_fmt(out_fmt_1),
        .out_illegal(out_illegal_1), .cnt_clr(cnt_clr), .illegal_cnt(illegal_cnt_1)
    );

    // Reference decode: immediates as signed integers built from the field layout.
    function automatic void ref_dec(input logic [31:0] i, input bit rv64, input bit csr,
                                    output longint imm, output logic [2:0] fmt, output bit ill);
        imm = 0;
        fmt = 3'd7;
        ill = 1'b0;
        case (i[6:0])
            7'h03, 7'h13, 7'h67: begin imm = $signed(i[31:20]); fmt = 3'd0; end
            7'h1B: if (rv64) begin imm = $signed(i[31:20]); fmt = 3'd0; end else ill = 1'b1;
            7'h3B: ill = !rv64;
            7'h23: begin imm = $signed({i[31:25], i[11:7]}); fmt = 3'd1; end
            7'h63: begin imm = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0}); fmt = 3'd2; end
            7'h37, 7'h17: begin imm = longint'($signed(i[31:12])) * 4096; fmt = 3'd3; end
            7'h6F: begin imm = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0}); fmt = 3'd4; end
            7'h73: if (csr && i[14]) begin imm = longint'(i[19:15]); fmt = 3'd5; end
            7'h33, 7'h0F: ;
            default: ill = 1'b1;
        endcase
    endfunction

    // Model: FIFO of accepted instructions (at most two) plus illegal counters.
    logic [31:0] mq[$];
    int cnt0_m = 0;
    int cnt1_m = 0;

    always @(posedge clk or negedge rst_n) begin
        bit acc, drn, il0, il1;
        longint im;
        logic [2:0] f;
        if (!rst_n) begin
            mq.delete();
            cnt0_m = 0;
            cnt1_m = 0;
        end else begin
            acc = in_valid && (mq.size() < 2);
            drn = (mq.size() > 0) && out_ready;
            ref_dec(in_inst, 1'b0, 1'b1, im, f, il0);
            ref_dec(in_inst, 1'b1, 1'b0, im, f, il1);
            if (cnt_clr) begin
                cnt0_m = (acc && il0) ? 1 : 0;
                cnt1_m = (acc && il1) ? 1 : 0;
            end else begin
                if (acc && il0 && cnt0_m < 65535) cnt0_m++;
                if (acc && il1 && cnt1_m < 15) cnt1_m++;
            end
            if (drn) void'(mq.pop_front());
            if (acc) mq.push_back(in_inst);
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0; in_inst = '0;
        #12;
        checks++;
        if ({out_valid_0, in_ready_0, out_inst_0, out_imm_0, out_fmt_0, out_illegal_0, illegal_cnt_0}
            !== {1'b0, 1'b1, 32'h0, 32'h0, 3'd7, 1'b0, 16'h0}) begin
            errors++;
            $display("FAIL reset_dut0 got v=%0b r=%0b inst=%h imm=%h fmt=%0d ill=%0b cnt=%0d exp 0 1 0 0 7 0 0",
                     out_valid_0, in_ready_0, out_inst_0, out_imm_0, out_fmt_0, out_illegal_0, illegal_cnt_0);
        end
        checks++;
        if ({out_valid_1, in_ready_1, out_inst_1, out_imm_1, out_fmt_1, out_illegal_1, illegal_cnt_1}
            !== {1'b0, 1'b1, 32'h0, 64'h0, 3'd7, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL reset_dut1 got v=%0b r=%0b inst=%h imm=%h fmt=%0d ill=%0b cnt=%0d exp 0 1 0 0 7 0 0",
                     out_valid_1, in_ready_1, out_inst_1, out_imm_1, out_fmt_1, out_illegal_1, illegal_cnt_1);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_decode_vectors();
        logic [31:0] vin[6]  = '{32'hFFF00093, 32'h800000B7, 32'hFE000EE3,
                                 32'h7C0FD073, 32'h0010009B, 32'h0000003B};
        logic [31:0] imm0[6] = '{32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFC,
                                 32'h0000001F, 32'h0, 32'h0};
        logic [2:0]  fmt0[6] = '{3'd0, 3'd3, 3'd2, 3'd5, 3'd7, 3'd7};
        logic        ill0[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [63:0] imm1[6] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000000,
                                 64'hFFFFFFFFFFFFFFFC, 64'h0, 64'h1, 64'h0};
        logic [2:0]  fmt1[6] = '{3'd0, 3'd3, 3'd2, 3'd7, 3'd0, 3'd7};
        out_ready = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (k > 0) begin
                checks++;
                if ({out_valid_0, out_inst_0, out_imm_0, out_fmt_0, out_illegal_0}
                    !== {1'b1, vin[k-1], imm0[k-1], fmt0[k-1], ill0[k-1]}) begin
                    errors++;
                    $display("FAIL vec32_%0d got v=%0b inst=%h imm=%h fmt=%0d ill=%0b exp v=1 imm=%h fmt=%0d ill=%0b",
                             k-1, out_valid_0, out_inst_0, out_imm_0, out_fmt_0, out_illegal_0,
                             imm0[k-1], fmt0[k-1], ill0[k-1]);
                end
                checks++;
                if ({out_valid_1, out_inst_1, out_imm_1, out_fmt_1, out_illegal_1}
                    !== {1'b1, vin[k-1], imm1[k-1], fmt1[k-1], 1'b0}) begin
                    errors++;
                    $display("FAIL vec64_%0d got v=%0b inst=%h imm=%h fmt=%0d ill=%0b exp v=1 imm=%h fmt=%0d ill=0",
                             k-1, out_valid_1, out_inst_1, out_imm_1, out_fmt_1, out_illegal_1,
                             imm1[k-1], fmt1[k-1]);
                end
            end
            if (k < 6) begin
                in_valid = 1'b1;
                in_inst = vin[k];
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a = 32'h00100093, b = 32'h00002023, c = 32'h0000006F;
        logic [31:0] exp_inst[6] = '{a, a, a, b, c, 32'h0};
        logic        exp_v[6]    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        exp_r[6]    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_inst = a;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if ({out_valid_0, in_ready_0, out_valid_1, in_ready_1} !== {exp_v[k], exp_r[k], exp_v[k], exp_r[k]}
                || (exp_v[k] && (out_inst_0 !== exp_inst[k] || out_inst_1 !== exp_inst[k]))) begin
                errors++;
                $display("FAIL b2b_step%0d got v=%0b/%0b r=%0b/%0b inst=%h/%h exp v=%0b r=%0b inst=%h",
                         k, out_valid_0, out_valid_1, in_ready_0, in_ready_1, out_inst_0, out_inst_1,
                         exp_v[k], exp_r[k], exp_inst[k]);
            end
            case (k)
                0: in_inst = b;
                1: in_inst = c;
                2: out_ready = 1'b1;
                4: in_valid = 1'b0;
                default: ;
            endcase
        end
    endtask

    task automatic test_counter();
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b0; cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        checks++;
        if ({illegal_cnt_0, illegal_cnt_1} !== {16'd0, 4'd0}) begin
            errors++;
            $display("FAIL cnt_clear got %0d/%0d exp 0/0", illegal_cnt_0, illegal_cnt_1);
        end
        for (int k = 0; k <= 17; k++) begin
            if (k > 0) begin
                checks++;
                if ({out_valid_0, out_illegal_0, out_fmt_0, out_illegal_1, out_fmt_1} !== {1'b1, 1'b1, 3'd7, 1'b1, 3'd7}) begin
                    errors++;
                    $display("FAIL cnt_illegal_%0d got v=%0b ill=%0b/%0b fmt=%0d/%0d exp 1 1/1 7/7",
                             k, out_valid_0, out_illegal_0, out_illegal_1, out_fmt_0, out_fmt_1);
                end
            end
            if (k < 17) begin
                in_valid = 1'b1;
                in_inst = 32'h0;
                @(negedge clk);
            end
        end
        checks++;
        if ({illegal_cnt_0, illegal_cnt_1} !== {16'd17, 4'd15}) begin
            errors++;
            $display("FAIL cnt_saturate got %0d/%0d exp 17/15", illegal_cnt_0, illegal_cnt_1);
        end
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({illegal_cnt_0, illegal_cnt_1} !== {16'd1, 4'd1}) begin
            errors++;
            $display("FAIL cnt_clr_with_illegal got %0d/%0d exp 1/1", illegal_cnt_0, illegal_cnt_1);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_inst = 32'hFFFFFFFF;
        @(negedge clk);
        in_inst = 32'h1234567F;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({out_valid_0, in_ready_0, out_valid_1, in_ready_1} !== 4'b1010) begin
            errors++;
            $display("FAIL rstmid_full got v=%0b/%0b r=%0b/%0b exp v=1/1 r=0/0",
                     out_valid_0, out_valid_1, in_ready_0, in_ready_1);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid_0, in_ready_0, illegal_cnt_0, out_fmt_0, out_valid_1, in_ready_1, illegal_cnt_1}
            !== {1'b0, 1'b1, 16'd0, 3'd7, 1'b0, 1'b1, 4'd0}) begin
            errors++;
            $display("FAIL rstmid_async got v=%0b/%0b r=%0b/%0b cnt=%0d/%0d fmt=%0d exp v=0 r=1 cnt=0 fmt=7",
                     out_valid_0, out_valid_1, in_ready_0, in_ready_1, illegal_cnt_0, illegal_cnt_1, out_fmt_0);
        end
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({out_valid_0, out_valid_1} !== 2'b00) begin
                errors++;
                $display("FAIL rstmid_stale_%0d got v=%0b/%0b exp 0/0", k, out_valid_0, out_valid_1);
            end
        end
    endtask

    task automatic test_random();
        logic [6:0] ops[13] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17,
                                7'h6F, 7'h1B, 7'h3B, 7'h73, 7'h33, 7'h0F};
        longint e0, e1;
        logic [2:0] f0, f1;
        bit il0, il1, ev, er;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            ev = mq.size() > 0;
            er = mq.size() < 2;
            checks++;
            if ({out_valid_0, in_ready_0, out_valid_1, in_ready_1} !== {ev, er, ev, er}) begin
                errors++;
                $display("FAIL rnd_hs_%0d got v=%0b/%0b r=%0b/%0b exp v=%0b r=%0b",
                         n, out_valid_0, out_valid_1, in_ready_0, in_ready_1, ev, er);
            end
            if (ev) begin
                ref_dec(mq[0], 1'b0, 1'b1, e0, f0, il0);
                ref_dec(mq[0], 1'b1, 1'b0, e1, f1, il1);
                checks++;
                if ({out_inst_0, out_imm_0, out_fmt_0, out_illegal_0} !== {mq[0], e0[31:0], f0, il0}) begin
                    errors++;
                    $display("FAIL rnd_out32_%0d got inst=%h imm=%h fmt=%0d ill=%0b exp inst=%h imm=%h fmt=%0d ill=%0b",
                             n, out_inst_0, out_imm_0, out_fmt_0, out_illegal_0, mq[0], e0[31:0], f0, il0);
                end
                checks++;
                if ({out_inst_1, out_imm_1, out_fmt_1, out_illegal_1} !== {mq[0], e1[63:0], f1, il1}) begin
                    errors++;
                    $display("FAIL rnd_out64_%0d got inst=%h imm=%h fmt=%0d ill=%0b exp inst=%h imm=%h fmt=%0d ill=%0b",
                             n, out_inst_1, out_imm_1, out_fmt_1, out_illegal_1, mq[0], e1[63:0], f1, il1);
                end
                if (out_ready)
                    $display("tx %0d inst=%08h imm32=%08h imm64=%016h fmt=%0d/%0d ill=%0b/%0b",
                             n, out_inst_0, out_imm_0, out_imm_1, out_fmt_0, out_fmt_1, out_illegal_0, out_illegal_1);
            end
            checks++;
            if ({illegal_cnt_0, illegal_cnt_1} !== {cnt0_m[15:0], cnt1_m[3:0]}) begin
                errors++;
                $display("FAIL rnd_cnt_%0d got %0d/%0d exp %0d/%0d", n, illegal_cnt_0, illegal_cnt_1, cnt0_m, cnt1_m);
            end
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 6);
            cnt_clr = ($urandom_range(0, 19) == 0);
            in_inst = $urandom;
            if ($urandom_range(0, 7) != 0) in_inst[6:0] = ops[$urandom_range(0, 12)];
        end
        @(negedge clk);
        in_valid = 1'b0;
        cnt_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_decode_vectors();
        test_back_to_back();
        test_counter();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
